// File: rtl/pixbuf_arbiter_pkg.sv
// Shared constants and enums for the framebuffer arbiter slice.
package pixbuf_arbiter_pkg;

    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 12;
    localparam int PIX_COUNT = 307200;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_DISP = 2'd1,
        G_FIFO = 2'd2,
        G_CLR  = 2'd3
    } grant_t;

endpackage

// File: rtl/pixbuf_wfifo.sv
// Small synchronous FIFO of {addr,data} writer pixels with flush.
module pixbuf_wfifo #(
    parameter int A_W   = 19,
    parameter int D_W   = 12,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [A_W-1:0]   push_addr,
    input  logic [D_W-1:0]   push_data,
    input  logic             pop,
    output logic [A_W-1:0]   head_addr,
    output logic [D_W-1:0]   head_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [A_W-1:0]   addr_mem_r [DEPTH];
    logic [D_W-1:0]   data_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (level_r == LVL_W'(DEPTH));
    assign empty     = (level_r == {LVL_W{1'b0}});
    assign level     = level_r;
    assign head_addr = addr_mem_r[rd_ptr_r];
    assign head_data = data_mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer and occupancy bookkeeping; flush discards everything queued.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Entry storage; contents are only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            addr_mem_r[wr_ptr_r] <= push_addr;
            data_mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/pixbuf_arbiter.sv
// Single-port framebuffer arbiter: display reads first, then queued writer
// pixels, then full-screen clear writes.
module pixbuf_arbiter #(
    parameter int ADDR_W     = pixbuf_arbiter_pkg::ADDR_W,
    parameter int DATA_W     = pixbuf_arbiter_pkg::DATA_W,
    parameter int PIX_COUNT  = pixbuf_arbiter_pkg::PIX_COUNT,
    parameter int FIFO_DEPTH = 4,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              CLK_25MH,
    input  logic              RST_n,
    input  logic              disp_en,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import pixbuf_arbiter_pkg::state_t;
    import pixbuf_arbiter_pkg::IDLE;
    import pixbuf_arbiter_pkg::CLEAR;
    import pixbuf_arbiter_pkg::grant_t;
    import pixbuf_arbiter_pkg::G_NONE;
    import pixbuf_arbiter_pkg::G_DISP;
    import pixbuf_arbiter_pkg::G_FIFO;
    import pixbuf_arbiter_pkg::G_CLR;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_COUNT - 1);

    state_t            state_r, state_s;
    grant_t            grant_s;
    logic [ADDR_W-1:0] clr_cnt_r, clr_cnt_s;
    logic [DATA_W-1:0] clr_color_r, clr_color_s;
    logic              disp_en_r;
    logic              push_s, flush_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_data_s;
    logic              fifo_full_s, fifo_empty_s;

    assign flush_s   = clr_start && (state_r == IDLE);
    assign wr_ready  = !fifo_full_s && (state_r == IDLE) && !clr_start;
    assign push_s    = wr_valid && wr_ready;
    assign clr_busy  = (state_r == CLEAR);
    assign disp_data = disp_en_r ? mem_rdata : {DATA_W{1'b0}};

    pixbuf_wfifo #(
        .A_W   (ADDR_W),
        .D_W   (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk       (CLK_25MH),
        .rst_n     (RST_n),
        .flush     (flush_s),
        .push      (push_s),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (grant_s == G_FIFO),
        .head_addr (head_addr_s),
        .head_data (head_data_s),
        .level     (fifo_level),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Fixed-priority grant; nothing touches the RAM while reset is held.
    always_comb begin
        grant_s = G_NONE;
        if (!RST_n) begin
            grant_s = G_NONE;
        end else if (disp_en) begin
            grant_s = G_DISP;
        end else if (!fifo_empty_s && (state_r == IDLE)) begin
            grant_s = G_FIFO;
        end else if (state_r == CLEAR) begin
            grant_s = G_CLR;
        end else begin
            grant_s = G_NONE;
        end
    end

    // RAM port mux driven by the winning source.
    always_comb begin
        mem_addr  = {ADDR_W{1'b0}};
        mem_we    = 1'b0;
        mem_wdata = {DATA_W{1'b0}};
        case (grant_s)
            G_DISP: mem_addr = disp_addr;
            G_FIFO: begin
                mem_addr  = head_addr_s;
                mem_we    = 1'b1;
                mem_wdata = head_data_s;
            end
            G_CLR: begin
                mem_addr  = clr_cnt_r;
                mem_we    = 1'b1;
                mem_wdata = clr_color_r;
            end
            default: begin
                mem_addr  = {ADDR_W{1'b0}};
                mem_we    = 1'b0;
                mem_wdata = {DATA_W{1'b0}};
            end
        endcase
    end

    // Clear sequencer: the counter only moves when its write actually wins.
    always_comb begin
        state_s     = state_r;
        clr_cnt_s   = clr_cnt_r;
        clr_color_s = clr_color_r;
        case (state_r)
            IDLE: begin
                if (clr_start) begin
                    state_s     = CLEAR;
                    clr_cnt_s   = {ADDR_W{1'b0}};
                    clr_color_s = clr_color;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                if (grant_s == G_CLR) begin
                    if (clr_cnt_r == LAST_ADDR) begin
                        state_s = IDLE;
                    end else begin
                        clr_cnt_s = clr_cnt_r + ADDR_W'(1);
                    end
                end else begin
                    state_s = CLEAR;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, clear context and display-valid pipeline registers.
    always_ff @(posedge CLK_25MH) begin
        if (!RST_n) begin
            state_r     <= IDLE;
            clr_cnt_r   <= {ADDR_W{1'b0}};
            clr_color_r <= {DATA_W{1'b0}};
            disp_en_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            clr_cnt_r   <= clr_cnt_s;
            clr_color_r <= clr_color_s;
            disp_en_r   <= disp_en;
        end
    end

endmodule

// File: tb/tb_pixbuf_arbiter.sv
// Directed plus randomized bench for pixbuf_arbiter with a RAM model and a
// queue-based reference model of the arbitration rules.
module tb_pixbuf_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 12;
    localparam int PIX    = 64;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = 3;
    localparam int RAM_N  = 2048;

    logic              CLK_25MH = 1'b0;
    logic              RST_n;
    logic              disp_en;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic [LVL_W-1:0]  fifo_level;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = 12'h000;

    always #20 CLK_25MH = ~CLK_25MH;

    pixbuf_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .PIX_COUNT  (PIX),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK_25MH   (CLK_25MH),
        .RST_n      (RST_n),
        .disp_en    (disp_en),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .clr_busy   (clr_busy),
        .fifo_level (fifo_level),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port RAM with 1-cycle synchronous read (read-before-write).
    logic [DATA_W-1:0] ram [RAM_N] = '{default: 12'h000};
    always @(posedge CLK_25MH) begin
        if (mem_we) ram[mem_addr[10:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[10:0]];
    end

    // Reference model state
    bit                m_clear = 1'b0;
    int                m_cidx  = 0;
    logic [DATA_W-1:0] m_color = 12'h000;
    logic [30:0]       m_q[$];
    logic [DATA_W-1:0] exp_mem [RAM_N] = '{default: 12'h000};
    bit                m_pde  = 1'b0;
    logic [DATA_W-1:0] m_pval = 12'h000;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs for the inputs already applied, advance model.
    task automatic step();
        logic [30:0]       head;
        bit                was, ready;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        int                gsrc;
        #1;
        if (!RST_n) begin
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            m_clear = 1'b0;
            m_q.delete();
            m_pde  = 1'b0;
            m_pval = 12'h000;
        end else begin
            ready  = (m_q.size() < DEPTH) && !m_clear && !clr_start;
            e_we   = 1'b0;
            e_addr = 19'd0;
            e_wd   = 12'h000;
            gsrc   = 0;
            if (disp_en) begin
                e_addr = disp_addr;
                gsrc   = 1;
            end else if (m_q.size() != 0 && !m_clear) begin
                head   = m_q[0];
                e_we   = 1'b1;
                e_addr = head[30:12];
                e_wd   = head[11:0];
                gsrc   = 2;
            end else if (m_clear) begin
                e_we   = 1'b1;
                e_addr = 19'(m_cidx);
                e_wd   = m_color;
                gsrc   = 3;
            end
            chk("mem_we",    32'(mem_we),     32'(e_we));
            chk("mem_addr",  32'(mem_addr),   32'(e_addr));
            if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
            chk("wr_ready",  32'(wr_ready),   32'(ready));
            chk("fifo_level",32'(fifo_level), 32'(m_q.size()));
            chk("clr_busy",  32'(clr_busy),   32'(m_clear));
            chk("disp_data", 32'(disp_data),  m_pde ? 32'(m_pval) : 32'd0);
            m_pde  = disp_en;
            m_pval = exp_mem[disp_addr[10:0]];
            if (e_we) exp_mem[e_addr[10:0]] = e_wd;
            if (gsrc == 2) void'(m_q.pop_front());
            was = m_clear;
            if (gsrc == 3) begin
                if (m_cidx == PIX - 1) m_clear = 1'b0;
                else m_cidx++;
            end
            if (!was && clr_start) begin
                m_clear = 1'b1;
                m_cidx  = 0;
                m_color = clr_color;
                m_q.delete();
            end else if (wr_valid && ready) begin
                m_q.push_back({wr_addr, wr_data});
            end
        end
        @(posedge CLK_25MH);
        @(negedge CLK_25MH);
    endtask

    task automatic quiet();
        disp_en = 1'b0; disp_addr = 19'd0; wr_valid = 1'b0; wr_addr = 19'd0;
        wr_data = 12'h000; clr_start = 1'b0; clr_color = 12'h000;
    endtask

    int n;

    initial begin
        quiet();
        RST_n = 1'b0;
        @(negedge CLK_25MH);
        for (int i = 0; i < 3; i++) step();
        RST_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 2; i++) step();

        // Preload address 1234 through the writer, then read it back
        wr_valid = 1'b1; wr_addr = 19'd1234; wr_data = 12'hABC;
        step();
        quiet();
        for (int i = 0; i < 2; i++) step();
        disp_en = 1'b1; disp_addr = 19'd1234;
        step();
        quiet();
        chk("disp_1234", 32'(disp_data), 32'h0ABC);
        step();

        // Six back-to-back pushes under continuous display traffic
        disp_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            disp_addr = 19'(i);
            wr_valid  = 1'b1;
            wr_addr   = 19'(10 + i);
            wr_data   = 12'(12'h100 + i);
            step();
        end
        chk("level_full", 32'(fifo_level), 32'd4);
        wr_valid = 1'b0; disp_en = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Unstalled clear
        clr_start = 1'b1; clr_color = 12'h0F0;
        step();
        clr_start = 1'b0;
        n = 0;
        while (clr_busy && n < 4 * PIX) begin
            wr_valid = 1'b1; wr_addr = 19'd3; wr_data = 12'h777;
            n++;
            step();
        end
        wr_valid = 1'b0;
        chk("clr_dur", 32'(n), 32'(PIX));
        for (int i = 0; i < 2; i++) step();
        for (int a = 0; a < PIX; a++) begin
            disp_en = 1'b1; disp_addr = 19'(a);
            step();
        end
        disp_en = 1'b0;
        step();

        // Three queued entries flushed by clr_start, then clear with 50% display
        disp_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            disp_addr = 19'(40 + i);
            wr_valid = 1'b1; wr_addr = 19'(5 + i); wr_data = 12'(12'hA00 + i);
            step();
        end
        clr_start = 1'b1; clr_color = 12'h3C5;
        step();
        clr_start = 1'b0; wr_valid = 1'b0;
        chk("flush_level", 32'(fifo_level), 32'd0);
        n = 0;
        while (clr_busy && n < 8 * PIX) begin
            disp_en   = n[0];
            disp_addr = 19'($urandom_range(0, PIX - 1));
            n++;
            step();
        end
        chk("clr_dur_50", 32'((n >= 2 * PIX - 1) && (n <= 2 * PIX + 1)), 32'd1);
        for (int i = 0; i < 3; i++) begin
            disp_en = 1'b1; disp_addr = 19'(5 + i);
            step();
            disp_en = 1'b0;
            chk("flushed_addr", 32'(disp_data), 32'h3C5);
        end
        quiet();
        step();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            disp_en   = ($urandom_range(0, 3) == 0);
            disp_addr = 19'($urandom_range(0, 127));
            wr_valid  = 1'($urandom_range(0, 1));
            wr_addr   = 19'($urandom_range(0, 127));
            wr_data   = 12'($urandom);
            clr_start = ($urandom_range(0, 299) == 0);
            clr_color = 12'($urandom);
            step();
        end
        quiet();
        for (int i = 0; i < 3 * PIX; i++) step();

        // Reset in the middle of a clear aborts it
        clr_start = 1'b1; clr_color = 12'h555;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        RST_n = 1'b0;
        step();
        RST_n = 1'b1;
        chk("rst_mid_busy", 32'(clr_busy), 32'd0);
        for (int i = 0; i < 3; i++) step();

        // Final RAM contents against the model
        for (int a = 0; a < 128; a++) chk("ram_final", 32'(ram[a]), 32'(exp_mem[a]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixbuf_arbiter.md
# pixbuf_arbiter

Single-port framebuffer arbiter and clear sequencer between the VGA scan-out path and the game-logic pixel writer. The display read port has absolute priority and gets a fixed 1-cycle read latency. Writer pixels pass through a small write FIFO and drain into free memory cycles. A full-screen clear command fills every framebuffer word with one colour using the remaining cycles.

## Interface
Parameters:
- ADDR_W, 19, framebuffer address width
- DATA_W, 12, pixel width (RGB 4:4:4)
- PIX_COUNT, 307200, number of framebuffer words (640×480)
- FIFO_DEPTH, 4, write FIFO entries (power of two)

Ports:
- CLK_25MH  in  1  pixel clock; reset RST_n, synchronous, active-low; clock CLK_25MH
- RST_n  in  1  synchronous active-low reset
- disp_en  in  1  display needs a read this cycle
- disp_addr  in  ADDR_W  display read address
- disp_data  out  DATA_W  read data, valid 1 cycle after disp_en; 0 otherwise
- wr_valid  in  1  writer presents a pixel
- wr_ready  out  1  FIFO accepts the pixel this cycle
- wr_addr  in  ADDR_W  writer address
- wr_data  in  DATA_W  writer pixel
- clr_start  in  1  one-cycle pulse: begin full clear
- clr_color  in  DATA_W  clear colour, sampled on clr_start
- clr_busy  out  1  clear in progress
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle synchronous read

## Operation
- Per-cycle grant, in priority order:
  - display read when disp_en=1;
  - else FIFO head write when fifo_level≠0 and state IDLE;
  - else clear write when state CLEAR;
  - else idle: mem_we=0, mem_addr=0.
- Display grant: mem_addr=disp_addr, mem_we=0.
- FSM states:
  - IDLE → CLEAR on clr_start. Side effects: latch clr_color, clear counter to 0, flush the FIFO (discard all entries, including a push in the same cycle).
  - CLEAR → IDLE after the write at address PIX_COUNT-1.
  - clr_start while in CLEAR is ignored.
- Clear counter advances only on cycles where the clear write is granted. Cycles stolen by the display do not advance it.
- wr_ready = (fifo_level < FIFO_DEPTH) && state==IDLE && !clr_start.
- Full FIFO blocks a push even if a pop occurs in the same cycle.
- Simultaneous push and pop in IDLE with a non-full FIFO leaves fifo_level unchanged.
- FIFO drains in strict order. Write ordering to the same address is preserved.
- No writer pixel is ever dropped except by the clr_start flush.

## Timing
- Reset values:
  - state IDLE, fifo_level 0, clr_busy 0, disp_data 0;
  - mem_we 0, mem_addr 0, mem_wdata 0;
  - wr_ready 1 once RST_n=1.
- Display latency: disp_en at cycle N gives disp_data=mem_rdata at N+1, gated by a registered copy of disp_en.
- Write latency: a pixel accepted at cycle N with an empty FIFO and disp_en=0 at N+1 reaches the RAM (mem_we=1) at N+1.
- clr_busy rises the cycle after clr_start and falls the cycle after the final clear write.
- Unstalled clear duration: PIX_COUNT cycles.
- Reset mid-clear aborts the clear. Memory contents are undefined-but-stable; no further writes occur.
- Counters and addresses use ADDR_W bits. The clear counter never exceeds PIX_COUNT-1.

## Structure
- Shared package holds:
  - ADDR_W, DATA_W, PIX_COUNT constants;
  - state enum {IDLE, CLEAR};
  - grant-source enum {G_NONE, G_DISP, G_FIFO, G_CLR}.
- One sub-module: pixbuf_wfifo, a synchronous FIFO with {addr,data} entries, push/pop/flush ports, level and full/empty outputs.
- Grant mux and FSM stay in the top module.

## Test plan
- Reset then idle: disp_data=0, mem_we=0, wr_ready=1, fifo_level=0.
- disp_en=1, disp_addr=1234 with a RAM model holding 0xABC there → mem_addr=1234 same cycle, disp_data=0xABC next cycle.
- Writer pushes 6 pixels (addr 10..15) back-to-back with disp_en=1 continuously:
  - wr_ready drops after 4 pushes (fifo_level=4);
  - after disp_en falls, RAM receives 10..15 in order.
- clr_start with clr_color=0x0F0 and no display traffic:
  - clr_busy high for exactly 307200 cycles;
  - every address reads 0x0F0;
  - wr_ready=0 throughout.
- clr_start while 3 entries are queued → FIFO flushed, those 3 addresses read clr_color afterwards.
- Clear with disp_en toggling 50% → clear completes in 614400 cycles ±1, display reads all correct, RST_n=0 mid-clear → clr_busy=0 next cycle.
